wptr_full: RTL and testbench
============================

# wptr_full

Write-side pointer and full-flag controller for the asynchronous FIFO, running entirely in the write clock domain. It accepts write requests, advances a binary/Gray write pointer, and drives the write address and clock enable straight into the dual-port FIFO memory. It compares its next Gray pointer against the read pointer that has already been synchronized into the write domain, and produces a registered full flag. It adds a programmable almost-full flag, a fill-level estimate and a sticky overflow flag.

## Interface
- ADDRSIZE, 4, memory address bits; DEPTH = 2**ADDRSIZE; pointers are ADDRSIZE+1 bits wide.
- AFULL_LEVEL, 12, fill level at or above which walmost_full asserts; legal range 1..DEPTH.

- wclk  in  1  write clock; every register is clocked on its rising edge.
- wrst_n  in  1  reset, asynchronous and active-low.
- winc  in  1  write request, one word per cycle while high.
- wq2_rptr  in  ADDRSIZE+1  read pointer (Gray), already 2-flop synchronized into wclk.
- wovf_clr  in  1  clears the sticky overflow flag.
- waddr  out  ADDRSIZE  memory write address = wbin[ADDRSIZE-1:0].
- wclken  out  1  memory write enable = winc & ~wfull (combinational).
- wptr  out  ADDRSIZE+1  registered Gray write pointer, sent to the read-domain synchronizer.
- wfull  out  1  registered full flag.
- walmost_full  out  1  registered, fill >= AFULL_LEVEL.
- wfill  out  ADDRSIZE+1  registered fill estimate, 0..DEPTH.
- wovf  out  1  sticky overflow: a write was attempted while full.

## Operation
- State: wbin (ADDRSIZE+1 bits, binary), wptr (Gray), wfull, walmost_full, wfill, wovf.
- Next-state arithmetic:
  - wbinnext = wbin + (winc & ~wfull), modulo 2**(ADDRSIZE+1).
  - wgraynext = (wbinnext >> 1) ^ wbinnext.
- Full detect: wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]}).
- Fill: rbin_s = Gray-to-binary(wq2_rptr); fill_next = wbinnext - rbin_s, modulo 2**(ADDRSIZE+1).
  - Register wfill = fill_next.
  - Register walmost_full = (fill_next >= AFULL_LEVEL).
- Overflow: set when winc & wfull; cleared by wovf_clr. Set wins if both occur in the same cycle.
- Write while full: this is not a write. wbin, wptr and waddr hold, and wclken = 0.
- Wrap-around: wbin rolls over from 2**(ADDRSIZE+1)-1 to 0. The MSB toggles each pass through memory. waddr wraps from DEPTH-1 to 0.
- Pessimism: wq2_rptr lags the real read pointer, so wfull and wfill may over-report occupancy. They never under-report it.
- Reset (wrst_n low, at any time including mid-burst): all registers clear immediately.
  - wbin = 0, wptr = 0, waddr = 0, wfull = 0, walmost_full = 0, wfill = 0, wovf = 0.
  - wclken then follows winc.

## Timing
- Write accepted at edge N when winc = 1 and wfull = 0. waddr and wptr advance at edge N.
- The memory writes the word at the old waddr on that same edge N.
- wfull asserts on the same edge as the write that takes occupancy to DEPTH. The next cycle's winc is therefore already blocked, with no overflow window.
- wfull deasserts on the first wclk edge after wq2_rptr reflects a read. That is at least 3 wclk after the read-domain pointer moves: 2 synchronizer cycles plus 1 register cycle.
- walmost_full and wfill update on the same edge as wfull, using the same wbinnext and wq2_rptr.
- wovf sets on the edge after the blocked request.
- wovf_clr takes effect on the next edge.

## Test plan
- Reset mid-burst: with wq2_rptr = 0, write 5 words, then pulse wrst_n low asynchronously between edges -> all outputs 0 immediately, with no clock needed. After release, the next write uses waddr = 0.
- Fill to full: hold wq2_rptr = 0 and winc = 1 for 16 cycles -> after the 16th edge: wfull = 1, wfill = 16, waddr = 0, wptr = 5'b11000, wclken = 0.
- Overflow: continuing from full, hold winc = 1 for 2 more cycles -> wptr stays 5'b11000 and wovf = 1. wovf stays 1 after winc drops, and clears one edge after a single-cycle wovf_clr. If wovf_clr and an overflowing write coincide, wovf stays 1.
- Almost-full threshold: from reset with wq2_rptr = 0, write 11 words -> walmost_full = 0 and wfill = 11. The 12th write -> walmost_full = 1 and wfill = 12.
- Release after read: full FIFO, set wq2_rptr = 5'b00110 (binary 4) -> next edge: wfull = 0, wfill = 12, walmost_full = 1. One more write -> wfill = 13 and waddr = 1.
- Wrap-around: write 40 words while the bench advances wq2_rptr to trail wptr by 3 words -> wfull is never 1 and wovf = 0. waddr sequence runs 0..15, 0..15, 0..7. wbin passes through 31 to 0, and wptr returns to 5'b00000 after the 32nd write.

Source files
------------

// File: rtl/wptr_full.sv
// Write-side pointer/full controller for an async FIFO: binary+Gray write pointer, full, almost-full, fill, sticky overflow.
// Latency: all flags registered, updated on the same edge as the accepted write; blocked writes (wfull) hold the pointer and set wovf.
module wptr_full #(
  parameter int ADDRSIZE    = 4,
  parameter int AFULL_LEVEL = 12
) (
  input  logic                wclk,
  input  logic                wrst_n,
  input  logic                winc,
  input  logic [ADDRSIZE:0]   wq2_rptr,
  input  logic                wovf_clr,
  output logic [ADDRSIZE-1:0] waddr,
  output logic                wclken,
  output logic [ADDRSIZE:0]   wptr,
  output logic                wfull,
  output logic                walmost_full,
  output logic [ADDRSIZE:0]   wfill,
  output logic                wovf
);

  localparam logic [ADDRSIZE:0] AFULL_THR = (ADDRSIZE+1)'(AFULL_LEVEL);

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] wbinnext;
  logic [ADDRSIZE:0] wgraynext;
  logic [ADDRSIZE:0] rbin_s;
  logic [ADDRSIZE:0] fill_next;
  logic              wfull_next;

  function automatic logic [ADDRSIZE:0] gray2bin(input logic [ADDRSIZE:0] g);
    logic [ADDRSIZE:0] b;
    b = g;
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  assign wclken    = winc & ~wfull;
  assign waddr     = wbin[ADDRSIZE-1:0];
  assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wclken};
  assign wgraynext = (wbinnext >> 1) ^ wbinnext;
  assign rbin_s    = gray2bin(wq2_rptr);
  assign fill_next = wbinnext - rbin_s;

  // Full when the next write pointer is one full lap ahead of the synchronized read pointer.
  assign wfull_next = (wgraynext == {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]});

  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wfill        <= '0;
      wovf         <= 1'b0;
    end else begin
      wbin         <= wbinnext;
      wptr         <= wgraynext;
      wfull        <= wfull_next;
      wfill        <= fill_next;
      walmost_full <= (fill_next >= AFULL_THR);
      // A blocked request takes priority over a same-cycle clear.
      if (winc && wfull) begin
        wovf <= 1'b1;
      end else if (wovf_clr) begin
        wovf <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_wptr_full.sv
// Self-checking bench for wptr_full: directed vector table, reset/wrap sequences, randomized run against a count-based model.
module tb_wptr_full;

  localparam int AS    = 4;
  localparam int DEPTH = 16;
  localparam int AF    = 12;

  logic          wclk = 1'b0;
  logic          wrst_n;
  logic          winc;
  logic [AS:0]   wq2_rptr;
  logic          wovf_clr;
  logic [AS-1:0] waddr;
  logic          wclken;
  logic [AS:0]   wptr;
  logic          wfull;
  logic          walmost_full;
  logic [AS:0]   wfill;
  logic          wovf;

  wptr_full #(.ADDRSIZE(AS), .AFULL_LEVEL(AF)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr), .wovf_clr(wovf_clr),
    .waddr(waddr), .wclken(wclken), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wfill(wfill), .wovf(wovf)
  );

  always #5 wclk = ~wclk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: total accepted writes and total reads seen by the write domain.
  int m_wr, m_rd, m_fill;
  bit m_full, m_af, m_ovf;

  typedef struct {
    bit          w;
    bit          c;
    int          rd;
    int          n;
    bit          e_full;
    int          e_fill;
    int          e_addr;
    logic [4:0]  e_ptr;
    bit          e_ovf;
    bit          e_af;
    bit          e_clken;
  } vec_t;

  vec_t tbl[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] to_gray(input int v);
    logic [4:0] b;
    b = v[4:0];
    return (b >> 1) ^ b;
  endfunction

  task automatic model_reset();
    m_wr = 0; m_rd = 0; m_fill = 0;
    m_full = 0; m_af = 0; m_ovf = 0;
  endtask

  // Apply one cycle of inputs (called just after a rising edge), then check post-edge state.
  task automatic step(input bit w, input bit c, input int rd);
    winc = w; wovf_clr = c; wq2_rptr = to_gray(rd);
    #1;
    chk("wclken", wclken, 32'(w && !m_full));
    chk("waddr_pre", waddr, m_wr % DEPTH);
    @(posedge wclk);
    if (w && m_full) m_ovf = 1;
    else if (c)      m_ovf = 0;
    if (w && !m_full) m_wr++;
    m_fill = m_wr - rd;
    m_full = (m_fill == DEPTH);
    m_af   = (m_fill >= AF);
    #1;
    chk("wfull", wfull, m_full);
    chk("wfill", wfill, m_fill);
    chk("walmost_full", walmost_full, m_af);
    chk("wovf", wovf, m_ovf);
    chk("wptr", wptr, to_gray(m_wr));
    chk("waddr", waddr, m_wr % DEPTH);
  endtask

  task automatic do_reset();
    winc = 0; wovf_clr = 0; wq2_rptr = '0;
    @(negedge wclk);
    wrst_n = 0;
    model_reset();
    @(negedge wclk);
    wrst_n = 1;
    @(posedge wclk);
    #1;
  endtask

  initial begin
    tbl[0]  = '{1, 0, 0, 11, 0, 11, 11, 5'b01110, 0, 0, 1};
    tbl[1]  = '{1, 0, 0, 1,  0, 12, 12, 5'b01010, 0, 1, 1};
    tbl[2]  = '{1, 0, 0, 4,  1, 16, 0,  5'b11000, 0, 1, 0};
    tbl[3]  = '{1, 0, 0, 2,  1, 16, 0,  5'b11000, 1, 1, 0};
    tbl[4]  = '{0, 0, 0, 1,  1, 16, 0,  5'b11000, 1, 1, 0};
    tbl[5]  = '{0, 1, 0, 1,  1, 16, 0,  5'b11000, 0, 1, 0};
    tbl[6]  = '{1, 0, 0, 1,  1, 16, 0,  5'b11000, 1, 1, 0};
    tbl[7]  = '{1, 1, 0, 1,  1, 16, 0,  5'b11000, 1, 1, 0};
    tbl[8]  = '{0, 1, 0, 1,  1, 16, 0,  5'b11000, 0, 1, 0};
    tbl[9]  = '{0, 0, 4, 1,  0, 12, 0,  5'b11000, 0, 1, 0};
    tbl[10] = '{1, 0, 4, 1,  0, 13, 1,  5'b11001, 0, 1, 1};

    wrst_n = 0; winc = 0; wovf_clr = 0; wq2_rptr = '0;
    model_reset();
    #12;
    chk("rst_wptr", wptr, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wfull", wfull, 0);
    chk("rst_wfill", wfill, 0);
    chk("rst_walmost_full", walmost_full, 0);
    chk("rst_wovf", wovf, 0);
    chk("rst_wclken", wclken, 0);
    do_reset();

    // Directed table: threshold, fill to full, overflow, clear, release after read.
    for (int i = 0; i < 11; i++) begin
      for (int j = 0; j < tbl[i].n; j++) step(tbl[i].w, tbl[i].c, tbl[i].rd);
      chk($sformatf("tbl%0d_wfull", i), wfull, tbl[i].e_full);
      chk($sformatf("tbl%0d_wfill", i), wfill, tbl[i].e_fill);
      chk($sformatf("tbl%0d_waddr", i), waddr, tbl[i].e_addr);
      chk($sformatf("tbl%0d_wptr", i), wptr, tbl[i].e_ptr);
      chk($sformatf("tbl%0d_wovf", i), wovf, tbl[i].e_ovf);
      chk($sformatf("tbl%0d_walmost_full", i), walmost_full, tbl[i].e_af);
      chk($sformatf("tbl%0d_wclken", i), wclken, tbl[i].e_clken);
    end

    // Asynchronous reset in the middle of a burst, between clock edges.
    do_reset();
    for (int i = 0; i < 5; i++) step(1, 0, 0);
    chk("burst_waddr", waddr, 5);
    #2 wrst_n = 0;
    #1;
    chk("midrst_wptr", wptr, 0);
    chk("midrst_waddr", waddr, 0);
    chk("midrst_wfull", wfull, 0);
    chk("midrst_wfill", wfill, 0);
    chk("midrst_walmost_full", walmost_full, 0);
    chk("midrst_wovf", wovf, 0);
    chk("midrst_wclken", wclken, 1);
    model_reset();
    #1 wrst_n = 1;
    step(1, 0, 0);
    chk("post_rst_waddr", waddr, 1);

    // Wrap-around with the read pointer trailing by 3 words.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      m_rd = (m_wr >= 3) ? m_wr - 3 : 0;
      chk("wrap_waddr_seq", waddr, i % DEPTH);
      step(1, 0, m_rd);
      chk("wrap_never_full", wfull, 0);
      if (i == 31) chk("wrap_wptr_zero", wptr, 0);
    end
    chk("wrap_wovf", wovf, 0);

    // Randomized run: writer-heavy phase, then reader-heavy phase.
    do_reset();
    for (int i = 0; i < 800; i++) begin
      bit w, c;
      if (i < 400) begin
        w = ($urandom_range(99) < 75);
        if ($urandom_range(99) < 33 && m_rd < m_wr) m_rd++;
      end else begin
        w = ($urandom_range(99) < 30);
        if ($urandom_range(99) < 70 && m_rd < m_wr) m_rd++;
      end
      c = ($urandom_range(99) < 5);
      step(w, c, m_rd);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish before 200000");
    $fatal(1, "timeout");
  end

endmodule
